// File: rtl/spi_master.sv
// Single-clock SPI master: frames a 10-bit command word on SS_n/MOSI and,
// for read-data commands, captures an 8-bit reply from MISO after a turnaround.
module spi_master #(
  parameter int RD_LATENCY = 2,
  parameter int MIN_IDLE   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] tx_word,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    SHIFT,
    TURN,
    RECV,
    STOP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic [9:0]  tx_reg;
  logic [7:0]  rx_sh;
  logic        load_tx;
  logic        shift_rx;
  logic        load_rd;
  logic        is_read;
  logic [3:0]  bit_idx;
  logic        ss_n_next;
  logic        mosi_next;
  logic        busy_next;
  logic        done_next;
  logic        rd_valid_next;

  assign is_read = (tx_reg[9:8] == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      tx_reg   <= 10'd0;
      rx_sh    <= 8'd0;
      rd_data  <= 8'd0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      if (load_tx)  tx_reg  <= tx_word;
      if (shift_rx) rx_sh   <= {rx_sh[6:0], MISO};
      if (load_rd)  rd_data <= {rx_sh[6:0], MISO};
      SS_n     <= ss_n_next;
      MOSI     <= mosi_next;
      busy     <= busy_next;
      done     <= done_next;
      rd_valid <= rd_valid_next;
    end
  end

  // One shared counter times SHIFT, TURN, RECV and STOP; it is cleared on every state exit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_tx    = 1'b0;
    shift_rx   = 1'b0;
    load_rd    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = 4'd0;
        if (start) begin
          load_tx    = 1'b1;
          state_next = START;
        end
      end
      START: begin
        state_next = CMD;
      end
      CMD: begin
        cnt_next   = 4'd0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == 4'd9) begin
          cnt_next   = 4'd0;
          state_next = is_read ? TURN : STOP;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      TURN: begin
        if (cnt == 4'(RD_LATENCY - 1)) begin
          cnt_next   = 4'd0;
          state_next = RECV;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      RECV: begin
        shift_rx = 1'b1;
        if (cnt == 4'd7) begin
          load_rd    = 1'b1;
          cnt_next   = 4'd0;
          state_next = STOP;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      STOP: begin
        if (cnt == 4'(MIN_IDLE - 1)) begin
          cnt_next   = 4'd0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: begin
        cnt_next   = 4'd0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered pins line up with it.
  always_comb begin
    bit_idx       = 4'd9 - cnt_next;
    ss_n_next     = (state_next == IDLE) || (state_next == STOP);
    mosi_next     = 1'b0;
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == STOP) && (state != STOP);
    rd_valid_next = 1'b0;
    if (state_next == CMD) begin
      mosi_next = tx_reg[9];
    end else if (state_next == SHIFT) begin
      mosi_next = tx_reg[bit_idx];
    end
    if (done_next && is_read) begin
      rd_valid_next = 1'b1;
    end
  end

endmodule
